// File: rtl/b12_pkg.sv
// ----------------------------------------------------------------------------
// b12_pkg : colour indices, key FSM state type and debounce default. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package b12_pkg;

  localparam int RED     = 0;
  localparam int GREEN   = 1;
  localparam int YELLOW  = 2;
  localparam int BLUE    = 3;
  localparam int NUM_KEY = 4;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HELD = 2'd2,
    RELQ = 2'd3
  } key_state_t;

  function automatic logic [NUM_KEY-1:0] key_onehot(input logic [1:0] idx);
    key_onehot = NUM_KEY'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce_bit.sv
// ----------------------------------------------------------------------------
// sync_debounce_bit : 2-flop sync, stability counter, debounced level, rise
// pulse for one asynchronous button. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_debounce_bit
  import b12_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_db_d;
  logic             r_rise;

  // r_cnt measures how long the synchronized level has disagreed with the
  // accepted level; any agreement restarts the measurement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_db  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_ONE;
      end
      r_db_d <= r_db;
      r_rise <= r_db & ~r_db_d;
    end
  end

  assign o_rise = r_rise;

endmodule

`default_nettype wire

// File: rtl/keypad_conditioner.sv
// ----------------------------------------------------------------------------
// keypad_conditioner : debounced one-pulse-per-press key and start conditioner.
// Optional AUTO_REPEAT_EN adds periodic key repeat while held. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module keypad_conditioner
  import b12_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = 32,
  parameter int CNT_W           = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_KEY-1:0] raw_key,
  input  logic               raw_start,
  output logic [NUM_KEY-1:0] k,
  output logic               start,
  output logic [1:0]         key_code,
  output logic               busy
);

  localparam logic [CNT_W-1:0] c_DB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  logic [NUM_KEY-1:0] r_key_meta;
  logic [NUM_KEY-1:0] r_key_s;
  key_state_t         r_state;
  key_state_t         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [NUM_KEY-1:0] r_k;
  logic [NUM_KEY-1:0] w_k_nxt;
  logic [1:0]         r_key_code;
  logic [1:0]         w_key_code_nxt;
  logic               w_single;
  logic [1:0]         w_single_idx;
  logic               w_match;
  logic               w_rpt_fire;

  always_comb begin
    w_single     = 1'b1;
    w_single_idx = 2'd0;
    case (r_key_s)
      4'b0001: w_single_idx = 2'(RED);
      4'b0010: w_single_idx = 2'(GREEN);
      4'b0100: w_single_idx = 2'(YELLOW);
      4'b1000: w_single_idx = 2'(BLUE);
      default: w_single     = 1'b0;
    endcase
  end

  assign w_match = (r_key_s == key_onehot(r_idx));

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_rcnt;

  assign w_rpt_fire = (r_state == HELD) && w_match && (r_rcnt == c_RPT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt <= '0;
    end else if ((r_state == HELD) && w_match && !w_rpt_fire) begin
      r_rcnt <= r_rcnt + c_ONE;
    end else begin
      r_rcnt <= '0;
    end
  end
`else
  // Repeat never fires; the parameter stays so both builds share one interface.
  assign w_rpt_fire = 1'b0 && (REPEAT_CYCLES != 0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_k_nxt        = '0;
    w_key_code_nxt = r_key_code;
    unique case (r_state)
      IDLE: begin
        if (w_single) begin
          w_idx_nxt   = w_single_idx;
          w_cnt_nxt   = c_DB_LOAD;
          w_state_nxt = QUAL;
        end
      end
      QUAL: begin
        if (!w_match) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - c_ONE;
        end else begin
          w_k_nxt        = key_onehot(r_idx);
          w_key_code_nxt = r_idx;
          w_state_nxt    = HELD;
        end
      end
      HELD: begin
        if (r_key_s == '0) begin
          w_cnt_nxt   = c_DB_LOAD;
          w_state_nxt = RELQ;
        end else if (w_rpt_fire) begin
          w_k_nxt = key_onehot(r_idx);
        end
      end
      RELQ: begin
        // Any high sample is treated as release bounce, not as a new press.
        if (r_key_s != '0) begin
          w_state_nxt = HELD;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_key_meta <= '0;
      r_key_s    <= '0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_k        <= '0;
      r_key_code <= '0;
    end else begin
      r_key_meta <= raw_key;
      r_key_s    <= r_key_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_k        <= w_k_nxt;
      r_key_code <= w_key_code_nxt;
    end
  end

  sync_debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_start_db (
    .clock   (clock),
    .reset_n (reset_n),
    .i_raw   (raw_start),
    .o_rise  (start)
  );

  assign k        = r_k;
  assign key_code = r_key_code;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_conditioner.sv
// ----------------------------------------------------------------------------
// tb_keypad_conditioner : directed + random stimulus, run-length reference
// model feeding a pulse scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_conditioner;

  localparam int c_D   = 8;
  localparam int c_REP = 32;
`ifdef AUTO_REPEAT_EN
  localparam bit c_AUTO = 1'b1;
`else
  localparam bit c_AUTO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] raw_key = 4'b0;
  logic       raw_start = 1'b0;
  logic [3:0] k;
  logic       start;
  logic [1:0] key_code;
  logic       busy;

  keypad_conditioner dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .raw_key   (raw_key),
    .raw_start (raw_start),
    .k         (k),
    .start     (start),
    .key_code  (key_code),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [3:0] kv;
    logic       st;
    logic [1:0] code;
  } exp_t;

  exp_t q[$];
  bit   exp_busy[int];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: key press accepted after D+1 identical one-hot samples,
  // released after D+1 consecutive all-low samples; start level follows after
  // D consecutive disagreeing samples. Samples lag raw drive by 3 edges.
  bit       m_ready = 1'b1;
  bit       m_cand  = 1'b0;
  int       m_run   = 0;
  int       m_idx   = 0;
  int       m_low   = 0;
  int       m_rep   = 0;
  bit [1:0] m_code  = 2'd0;
  bit       m_lvl   = 1'b0;
  int       m_srun  = 0;
  bit       m_spend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b1; m_cand = 1'b0; m_run = 0; m_idx = 0; m_low = 0; m_rep = 0;
    m_code = 2'd0; m_lvl = 1'b0; m_srun = 0; m_spend = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] s, input logic ss);
    logic [3:0] ek;
    logic       est;
    logic [3:0] oh;
    exp_t       e;
    ek  = 4'b0;
    est = m_spend;
    m_spend = 1'b0;
    oh  = 4'(1) << m_idx;
    if (m_ready && !m_cand) begin
      if ($countones(s) == 1) begin
        m_cand = 1'b1;
        m_run  = 1;
        for (int i = 0; i < 4; i++) if (s[i]) m_idx = i;
      end
    end else if (m_cand) begin
      if (s == oh) begin
        m_run++;
        if (m_run == c_D + 1) begin
          ek = oh; m_code = 2'(m_idx);
          m_cand = 1'b0; m_ready = 1'b0; m_low = 0; m_rep = 0;
        end
      end else begin
        m_cand = 1'b0;
      end
    end else if (m_low == 0) begin
      if (s == 4'b0) begin
        m_low = 1; m_rep = 0;
      end else if (s == oh) begin
        m_rep++;
        if (c_AUTO && m_rep == c_REP) begin
          ek = oh; m_rep = 0;
        end
      end else begin
        m_rep = 0;
      end
    end else begin
      m_rep = 0;
      if (s != 4'b0) m_low = 0;
      else begin
        m_low++;
        if (m_low == c_D + 1) m_ready = 1'b1;
      end
    end
    if (ss != m_lvl) begin
      m_srun++;
      if (m_srun == c_D) begin
        m_lvl = ss; m_srun = 0;
        if (ss) m_spend = 1'b1;
      end
    end else begin
      m_srun = 0;
    end
    exp_busy[cyc + 3] = !(m_ready && !m_cand);
    if (ek != 4'b0 || est) begin
      e.stamp = cyc + 3; e.kv = ek; e.st = est; e.code = m_code;
      q.push_back(e);
    end
  endtask

  task automatic tick(input logic [3:0] kv, input logic sv);
    @(posedge clock); #1;
    reset_n   = 1'b1;
    raw_key   = kv;
    raw_start = sv;
    model_step(kv, sv);
  endtask

  task automatic ticks(input int n, input logic [3:0] kv, input logic sv);
    for (int i = 0; i < n; i++) tick(kv, sv);
  endtask

  task automatic reset_pulse(input int n);
    @(posedge clock); #1;
    reset_n = 1'b0;
    while (q.size() > 0 && q[$].stamp >= cyc) void'(q.pop_back());
    for (int i = 0; i < 3; i++) exp_busy[cyc + i] = 1'b0;
    model_reset();
    model_step(4'b0, 1'b0);
    @(negedge clock);
    chk("rst_k", int'(k), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_busy", int'(busy), 0);
    for (int i = 1; i < n; i++) begin
      @(posedge clock); #1;
      model_step(4'b0, 1'b0);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].stamp < cyc) begin
      e = q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL pulse_missing: no output seen, expected k=%b start=%b at cycle %0d",
               e.kv, e.st, e.stamp);
    end
    if (q.size() > 0 && q[0].stamp == cyc) begin
      e = q.pop_front();
      chk("k_pulse", int'(k), int'(e.kv));
      chk("start_pulse", int'(start), int'(e.st));
      chk("key_code", int'(key_code), int'(e.code));
    end else begin
      chk("quiet_outputs", int'({k, start}), 0);
    end
    if (exp_busy.exists(cyc)) begin
      chk("busy", int'(busy), int'(exp_busy[cyc]));
      exp_busy.delete(cyc);
    end
  end

  initial begin
    logic [3:0] kv;
    logic       sv;
    int         len;
    int         r;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("init_k", int'(k), 0);
    chk("init_start", int'(start), 0);
    chk("init_key_code", int'(key_code), 0);
    chk("init_busy", int'(busy), 0);
    ticks(5, 4'b0, 1'b0);

    // clean YELLOW press
    ticks(20, 4'b0100, 1'b0);
    ticks(20, 4'b0000, 1'b0);
    // GREEN bouncing then held
    for (int i = 0; i < 5; i++) ticks(3, (i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0);
    ticks(20, 4'b0010, 1'b0);
    ticks(20, 4'b0000, 1'b0);
    // chord then single RED
    ticks(30, 4'b0011, 1'b0);
    ticks(20, 4'b0001, 1'b0);
    ticks(20, 4'b0000, 1'b0);
    // RED with release glitches, then re-press
    ticks(15, 4'b0001, 1'b0);
    ticks(2, 4'b0000, 1'b0);
    ticks(2, 4'b0001, 1'b0);
    ticks(2, 4'b0000, 1'b0);
    ticks(2, 4'b0001, 1'b0);
    ticks(12, 4'b0000, 1'b0);
    ticks(15, 4'b0001, 1'b0);
    ticks(15, 4'b0000, 1'b0);
    // start alone, then start with a simultaneous BLUE press
    ticks(20, 4'b0000, 1'b1);
    ticks(20, 4'b0000, 1'b0);
    ticks(20, 4'b1000, 1'b1);
    ticks(20, 4'b0000, 1'b0);
    // long BLUE hold (repeat behaviour depends on build)
    ticks(100, 4'b1000, 1'b0);
    ticks(20, 4'b0000, 1'b0);
    // reset in the middle of a YELLOW qualification
    ticks(8, 4'b0100, 1'b0);
    reset_pulse(3);
    ticks(25, 4'b0000, 1'b0);

    for (int blk = 0; blk < 60; blk++) begin
      len = $urandom_range(1, 24);
      r   = $urandom_range(0, 9);
      if (r < 3)      kv = 4'b0;
      else if (r < 8) kv = 4'(1) << $urandom_range(0, 3);
      else            kv = 4'($urandom_range(0, 15));
      sv = 1'($urandom_range(0, 1));
      if (blk == 30) reset_pulse(2);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) tick(kv ^ 4'($urandom_range(1, 15)), ~sv);
        else                           tick(kv, sv);
      end
    end

    ticks(40, 4'b0000, 1'b0);
    @(negedge clock);
    while (q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL pulse_missing: expected k=%b start=%b at cycle %0d never checked",
               q[0].kv, q[0].st, q[0].stamp);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
